// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths, wait counter width and FSM states.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_t;

endpackage

// File: rtl/apb_wait_gen.sv
// APB slave sequencing: tracks setup/access phases, counts wait states and
// flags the edge on which the slave turns ready, completes or aborts.
module apb_wait_gen
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic psel,
  input  logic penable,
  output logic setup_edge,
  output logic ready_set,
  output logic done,
  output logic abort
);

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

  apb_slv_state_t state, state_next;
  logic [WAIT_CNT_W-1:0] cnt, cnt_next;

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state decode and per-edge event strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    setup_edge = 1'b0;
    ready_set  = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state)
      IDLE: begin
        if (psel && !penable) begin
          setup_edge = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = READY;
            ready_set  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (penable) begin
          if (cnt == '0) begin
            state_next = READY;
            ready_set  = 1'b1;
          end else begin
            cnt_next = cnt - WAIT_CNT_W'(1);
          end
        end
      end
      READY: begin
        if (!psel) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else if (penable) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a DEPTH-word register file with configurable wait states.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite_e,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic setup_edge, ready_set, done, abort;

  logic [IDX_W-1:0]  a_q;
  logic              w_q;
  logic              err_q;
  logic              setup_err;
  logic [IDX_W-1:0]  eff_idx;
  logic              eff_w;
  logic              eff_err;
  logic [DATA_W-1:0] mem [DEPTH];

  apb_wait_gen #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_gen (
    .clk       (clk),
    .reset     (reset),
    .psel      (psel),
    .penable   (penable),
    .setup_edge(setup_edge),
    .ready_set (ready_set),
    .done      (done),
    .abort     (abort)
  );

  // Out-of-range accesses are flagged once at setup, so only the index bits
  // need to be kept for the rest of the transfer.
  assign setup_err = ({1'b0, paddr} >= DEPTH_EXT);

  // With zero wait states READY is entered on the setup edge itself, before
  // a_q/w_q/err_q are loaded, so the live setup values must be used there.
  always_comb begin
    eff_idx = a_q;
    eff_w   = w_q;
    eff_err = err_q;
    if (setup_edge) begin
      eff_idx = paddr[IDX_W-1:0];
      eff_w   = pwrite_e;
      eff_err = setup_err;
    end
  end

  // Capture transfer attributes at the setup edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      w_q   <= 1'b0;
      err_q <= 1'b0;
    end else if (setup_edge) begin
      a_q   <= paddr[IDX_W-1:0];
      w_q   <= pwrite_e;
      err_q <= setup_err;
    end
  end

  // Storage: cleared on reset, written only on an in-range completion edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (done && w_q && !err_q) begin
      mem[a_q] <= pdata;
    end
  end

  // Registered response: raised on READY entry, dropped on completion/abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else if (ready_set) begin
      pready  <= 1'b1;
      pslverr <= eff_err;
      prdata  <= (!eff_w && !eff_err) ? mem[eff_idx] : '0;
    end else if (done || abort) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (2 and 0 wait states) on a shared
// bus with per-instance psel, checked every cycle against a transfer model.
module tb_apb_slave_mem;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W_A   = 2;
  localparam int unsigned W_B   = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite_e = 1'b0;
  logic [7:0] paddr = '0;
  logic [7:0] pdata = '0;
  int         sel = 0;

  logic       psel_a, psel_b;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b;

  assign psel_a = psel && (sel == 0);
  assign psel_b = psel && (sel == 1);

  apb_slave_mem #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W_A)
  ) u_dut_a (
    .clk(clk), .reset(reset), .psel(psel_a), .penable(penable),
    .pwrite_e(pwrite_e), .paddr(paddr), .pdata(pdata),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_slave_mem #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W_B)
  ) u_dut_b (
    .clk(clk), .reset(reset), .psel(psel_b), .penable(penable),
    .pwrite_e(pwrite_e), .paddr(paddr), .pdata(pdata),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b)
  );

  always #5 clk = ~clk;

  // Model state per instance (0 = two wait states, 1 = zero wait states).
  logic [7:0] mmem   [2][64];
  logic       exp_rdy[2];
  logic       exp_err[2];
  logic [7:0] exp_rd [2];
  bit         started = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("a_pready",  32'(pready_a),  32'(exp_rdy[0]));
      chk("a_pslverr", 32'(pslverr_a), 32'(exp_err[0]));
      chk("a_prdata",  32'(prdata_a),  32'(exp_rd[0]));
      chk("b_pready",  32'(pready_b),  32'(exp_rdy[1]));
      chk("b_pslverr", 32'(pslverr_b), 32'(exp_err[1]));
      chk("b_prdata",  32'(prdata_b),  32'(exp_rd[1]));
    end
  end

  function automatic int unsigned wc(input int d);
    return (d == 0) ? W_A : W_B;
  endfunction

  function automatic logic cur_rdy(input int d);
    return (d == 0) ? pready_a : pready_b;
  endfunction

  function automatic logic cur_err(input int d);
    return (d == 0) ? pslverr_a : pslverr_b;
  endfunction

  function automatic logic [7:0] cur_rd(input int d);
    return (d == 0) ? prdata_a : prdata_b;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d]  = '0;
      for (int k = 0; k < 64; k++) mmem[d][k] = '0;
    end
  endtask

  task automatic enter_ready(input int d, input bit w, input logic [7:0] a, input bit err);
    exp_rdy[d] = 1'b1;
    exp_err[d] = err;
    exp_rd[d]  = (!w && !err) ? mmem[d][a[5:0]] : 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1; psel = 1'b0; penable = 1'b0; sel = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_model();
    started = 1;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One transfer. abort_at >= 0 keeps psel for that many access cycles and
  // then drops it; rst_rdy asserts reset during the ready cycle. Address and
  // direction are scrambled during access to show they are ignored.
  task automatic xfer(input int d, input bit w, input logic [7:0] a, input logic [7:0] dt,
                      input int abort_at, input bit rst_rdy,
                      output logic [7:0] rd, output logic er, output int first_rdy);
    int unsigned wn;
    bit err;
    wn = wc(d);
    err = (a >= 8'(DEPTH));
    rd = '0; er = 1'b0; first_rdy = 0;
    sel = d; psel = 1'b1; penable = 1'b0; pwrite_e = w; paddr = a; pdata = dt;
    @(posedge clk); #1;
    if (wn == 0) enter_ready(d, w, a, err);
    for (int i = 1; i <= int'(wn) + 1; i++) begin
      if (i - 1 == abort_at) begin
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
        return;
      end
      penable = 1'b1; paddr = ~a; pwrite_e = ~w;
      if (rst_rdy && i == int'(wn) + 1) reset = 1'b1;
      if (cur_rdy(d) === 1'b1 && first_rdy == 0) begin
        first_rdy = i; rd = cur_rd(d); er = cur_err(d);
      end
      @(posedge clk); #1;
      if (rst_rdy && i == int'(wn) + 1) begin
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        clear_model();
        return;
      end
      if (i == int'(wn)) enter_ready(d, w, a, err);
      if (i == int'(wn) + 1) begin
        if (w && !err) mmem[d][a[5:0]] = dt;
        exp_rdy[d] = 1'b0;
        exp_err[d] = 1'b0;
      end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         fr;

    do_reset();
    idle(1);

    // Read of a fresh location: two wait states, ready on the third access cycle.
    xfer(0, 1'b0, 8'h05, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd05_latency", 32'(fr), 32'd3);
    chk("rd05_data",    32'(rd), 32'h00);
    chk("rd05_err",     32'(er), 32'd0);
    idle(1);

    // Write then back-to-back read.
    xfer(0, 1'b1, 8'h10, 8'hA5, -1, 1'b0, rd, er, fr);
    chk("wr10_latency", 32'(fr), 32'd3);
    chk("wr10_err",     32'(er), 32'd0);
    xfer(0, 1'b0, 8'h10, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd10_data",    32'(rd), 32'hA5);
    xfer(0, 1'b0, 8'h11, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd11_data",    32'(rd), 32'h00);
    xfer(0, 1'b0, 8'h0F, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd0f_data",    32'(rd), 32'h00);

    // Enable without setup is ignored.
    psel = 1'b1; penable = 1'b1; sel = 0;
    repeat (2) begin @(posedge clk); #1; end
    idle(1);

    // Out-of-range write is flagged and discarded; in-range data untouched.
    xfer(0, 1'b1, 8'h00, 8'h5A, -1, 1'b0, rd, er, fr);
    xfer(0, 1'b1, 8'h40, 8'h3C, -1, 1'b0, rd, er, fr);
    chk("wr40_latency", 32'(fr), 32'd3);
    chk("wr40_err",     32'(er), 32'd1);
    xfer(0, 1'b0, 8'h00, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd00_data",    32'(rd), 32'h5A);
    xfer(0, 1'b0, 8'h40, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd40_data",    32'(rd), 32'h00);
    chk("rd40_err",     32'(er), 32'd1);
    xfer(0, 1'b0, 8'h3F, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd3f_err",     32'(er), 32'd0);
    xfer(0, 1'b0, 8'hFF, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rdff_err",     32'(er), 32'd1);
    idle(2);

    // Zero-wait instance.
    xfer(1, 1'b1, 8'h01, 8'h11, -1, 1'b0, rd, er, fr);
    chk("b_wr01_latency", 32'(fr), 32'd1);
    xfer(1, 1'b0, 8'h01, 8'h00, -1, 1'b0, rd, er, fr);
    chk("b_rd01_latency", 32'(fr), 32'd1);
    chk("b_rd01_data",    32'(rd), 32'h11);
    xfer(1, 1'b0, 8'h50, 8'h00, -1, 1'b0, rd, er, fr);
    chk("b_rd50_err",     32'(er), 32'd1);
    idle(1);

    // Abort in the first wait cycle, then in the ready cycle.
    xfer(0, 1'b1, 8'h02, 8'h77, 0, 1'b0, rd, er, fr);
    chk("abort_wait_noready", 32'(fr), 32'd0);
    idle(1);
    xfer(0, 1'b1, 8'h02, 8'h66, int'(W_A), 1'b0, rd, er, fr);
    idle(1);
    xfer(0, 1'b0, 8'h02, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd02_after_abort", 32'(rd), 32'h00);
    idle(1);

    // Reset during the ready cycle of a write.
    xfer(0, 1'b1, 8'h03, 8'h99, -1, 1'b1, rd, er, fr);
    xfer(0, 1'b0, 8'h03, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd03_after_reset", 32'(rd), 32'h00);
    chk("rd03_latency",     32'(fr), 32'd3);
    xfer(0, 1'b0, 8'h10, 8'h00, -1, 1'b0, rd, er, fr);
    chk("rd10_after_reset", 32'(rd), 32'h00);
    idle(2);

    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
